ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/risc_pkg.sv | 27 ++
 rtl/ifetch_buf.sv | 83 ++++++++
 rtl/ifetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared fetch-side definitions: fetch FSM encoding, reset PC,
// instruction field positions and instruction width.
package risc_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000;

  // Control-unit fields carved straight out of the instruction word
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int FUNC_MSB = 10;
  localparam int FUNC_LSB = 0;
  localparam int OPC_W    = OPC_MSB - OPC_LSB + 1;
  localparam int FUNC_W   = FUNC_MSB - FUNC_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Redirect targets are always forced onto a word boundary
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return a & ~(INSTR_W'(3));
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Small instruction FIFO (depth 1 or 2) holding {pc, instr} pairs.
// Entry 0 is always the head; a pop shifts the remaining entry down.
module ifetch_buf
  import risc_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [INSTR_W-1:0] push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [INSTR_W-1:0] head_instr,
  output logic [INSTR_W-1:0] head_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic          pop_eff;
  logic          push_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  // With a simultaneous pop the new word lands one slot lower
  assign wr_idx   = count_q - CW'(pop_eff);

  // Per-entry next value: write, shift down on pop, or hold
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    if (gi < DEPTH - 1) begin : g_shift
      assign ent_d[gi] = (push_eff && (wr_idx == CW'(gi))) ? entry_t'{pc: push_pc, instr: push_instr}
                       : pop_eff ? ent_q[gi+1] : ent_q[gi];
    end else begin : g_last
      assign ent_d[gi] = (push_eff && (wr_idx == CW'(gi))) ? entry_t'{pc: push_pc, instr: push_instr}
                       : ent_q[gi];
    end
  end

  // Occupancy: a flush wins over any concurrent pop
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Entry storage and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Head is presented as zero whenever nothing is buffered
  assign head_instr = empty ? '0 : ent_q[0].instr;
  assign head_pc    = empty ? '0 : ent_q[0].pc;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding-request memory FSM feeding
// a small instruction buffer, with branch redirect and flush.
// Build option: define IFETCH_BUF2_EN for a 2-entry buffer (default 1).
module ifetch_unit
  import risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [INSTR_W-1:0] br_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc_out,
  output logic [OPC_W-1:0]   opcode,
  output logic [FUNC_W-1:0]  func
);

`ifdef IFETCH_BUF2_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] fetch_pc_q;
  logic [INSTR_W-1:0] req_addr_q;
  logic               req_q;
  logic [INSTR_W-1:0] br_pc;
  logic               buf_full;
  logic               buf_empty;
  logic               buf_push;
  logic               buf_pop;
  logic [INSTR_W-1:0] head_instr;
  logic [INSTR_W-1:0] head_pc;

  assign br_pc    = word_align(br_target);
  // Only an un-redirected response in REQ carries a useful word
  assign buf_push = (state_q == ST_REQ) && imem_ack && !br_taken;
  assign buf_pop  = instr_valid && instr_ready;

  // Fetch FSM with registered request/address outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      req_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_taken) begin
            fetch_pc_q <= br_pc;
          end else if (!buf_full) begin
            state_q    <= ST_REQ;
            req_q      <= 1'b1;
            req_addr_q <= fetch_pc_q;
          end
        end
        ST_REQ: begin
          if (br_taken) begin
            fetch_pc_q <= br_pc;
            if (imem_ack) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end else begin
              // Request stays up; its response will be thrown away
              state_q <= ST_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= fetch_pc_q + INSTR_W'(4);
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
          end
        end
        ST_DROP: begin
          if (br_taken) begin
            fetch_pc_q <= br_pc;
          end
          if (imem_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = req_addr_q;

  ifetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_instr(imem_rdata),
    .push_pc   (req_addr_q),
    .pop       (buf_pop),
    .flush     (br_taken),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_instr(head_instr),
    .head_pc   (head_pc)
  );

  assign instr_valid = !buf_empty;
  assign instr       = head_instr;
  assign pc_out      = head_pc;
  assign opcode      = head_instr[OPC_MSB:OPC_LSB];
  assign func        = head_instr[FUNC_MSB:FUNC_LSB];

endmodule
